// File: rtl/hpi_pkg.sv
// Shared types and constants for the CY7C67200 HPI bus master.
package hpi_pkg;

  typedef enum logic [1:0] {
    REG_READ  = 2'b00,
    REG_WRITE = 2'b01,
    MEM_READ  = 2'b10,
    MEM_WRITE = 2'b11
  } hpi_op_t;

  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  typedef enum logic [2:0] {
    ST_RST_HOLD = 3'd0,
    ST_IDLE     = 3'd1,
    ST_SETUP    = 3'd2,
    ST_STROBE   = 3'd3,
    ST_HOLD     = 3'd4,
    ST_RECOVER  = 3'd5
  } hpi_state_t;

  function automatic logic op_is_mem(hpi_op_t op);
    return (op == MEM_READ) || (op == MEM_WRITE);
  endfunction

  function automatic logic op_is_write(hpi_op_t op);
    return (op == REG_WRITE) || (op == MEM_WRITE);
  endfunction

endpackage

// File: rtl/hpi_phase_timer.sv
// Loadable down-counter that times every bus phase and the chip reset hold.
module hpi_phase_timer #(
  parameter logic [15:0] RESET_VAL = 16'd0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  output logic        done_o
);

  logic [15:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= RESET_VAL;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != 16'd0) begin
      count_q <= count_q - 16'd1;
    end
  end

  assign done_o = (count_q == 16'd0);

endmodule

// File: rtl/hpi_bus_master.sv
// HPI initiator: turns one request at a time into CS_N/RD_N/WR_N pin cycles.
module hpi_bus_master
  import hpi_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES   = 1,
  parameter int unsigned STROBE_CYCLES  = 4,
  parameter int unsigned HOLD_CYCLES    = 1,
  parameter int unsigned RECOVER_CYCLES = 2,
  parameter int unsigned RST_CYCLES     = 1000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [1:0]  req_reg,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  inout  wire  [15:0] OTG_DATA,
  output logic [1:0]  OTG_ADDR,
  output logic        OTG_CS_N,
  output logic        OTG_RD_N,
  output logic        OTG_WR_N,
  output logic        OTG_RST_N,
  input  logic        OTG_INT,
  output logic        int_sync
);

  localparam logic [15:0] SETUP_LOAD   = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0] STROBE_LOAD  = 16'(STROBE_CYCLES - 1);
  localparam logic [15:0] HOLD_LOAD    = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] RECOVER_LOAD = 16'(RECOVER_CYCLES - 1);

  hpi_state_t  state_q, state_d;
  hpi_op_t     op_q, op_d;
  logic [1:0]  reg_q, reg_d;
  logic [15:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        addr_phase_q, addr_phase_d;

  logic        tmr_load, tmr_done;
  logic [15:0] tmr_load_val;

  logic        cs_n_q, rd_n_q, wr_n_q, data_oe_q, otg_rst_n_q;
  logic [1:0]  otg_addr_q;
  logic [15:0] data_out_q, rdata_q;
  logic        int_meta_q, int_sync_q;

  logic bus_active_d, wr_phase_d, capture;

  hpi_phase_timer #(.RESET_VAL(16'(RST_CYCLES - 1))) u_timer (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .done_o     (tmr_done)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    reg_d        = reg_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    addr_phase_d = addr_phase_q;
    tmr_load     = 1'b0;
    tmr_load_val = 16'd0;
    case (state_q)
      ST_RST_HOLD: if (tmr_done) state_d = ST_IDLE;
      ST_IDLE: if (req_valid) begin
        op_d         = hpi_op_t'(req_op);
        reg_d        = req_reg;
        addr_d       = req_addr;
        wdata_d      = req_wdata;
        addr_phase_d = op_is_mem(hpi_op_t'(req_op));
        state_d      = ST_SETUP;
        tmr_load     = 1'b1;
        tmr_load_val = SETUP_LOAD;
      end
      ST_SETUP: if (tmr_done) begin
        state_d = ST_STROBE; tmr_load = 1'b1; tmr_load_val = STROBE_LOAD;
      end
      ST_STROBE: if (tmr_done) begin
        state_d = ST_HOLD; tmr_load = 1'b1; tmr_load_val = HOLD_LOAD;
      end
      ST_HOLD: if (tmr_done) begin
        state_d = ST_RECOVER; tmr_load = 1'b1; tmr_load_val = RECOVER_LOAD;
      end
      ST_RECOVER: if (tmr_done) begin
        // A finished address phase chains straight into the data phase on register 0.
        if (addr_phase_q) begin
          addr_phase_d = 1'b0;
          state_d      = ST_SETUP;
          tmr_load     = 1'b1;
          tmr_load_val = SETUP_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_RST_HOLD;
    endcase
  end

  // Pin registers are computed from next state so they line up with state_q.
  assign bus_active_d = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
  assign wr_phase_d   = addr_phase_d || op_is_write(op_d);
  assign capture      = (state_q == ST_STROBE) && tmr_done && !addr_phase_q && !op_is_write(op_q);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_RST_HOLD;
      op_q         <= REG_READ;
      reg_q        <= 2'd0;
      addr_q       <= 16'd0;
      wdata_q      <= 16'd0;
      addr_phase_q <= 1'b0;
      cs_n_q       <= 1'b1;
      rd_n_q       <= 1'b1;
      wr_n_q       <= 1'b1;
      data_oe_q    <= 1'b0;
      data_out_q   <= 16'd0;
      otg_addr_q   <= 2'd0;
      otg_rst_n_q  <= 1'b0;
      rdata_q      <= 16'd0;
      int_meta_q   <= 1'b0;
      int_sync_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      reg_q        <= reg_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      addr_phase_q <= addr_phase_d;
      cs_n_q       <= !bus_active_d;
      rd_n_q       <= !((state_d == ST_STROBE) && !wr_phase_d);
      wr_n_q       <= !((state_d == ST_STROBE) && wr_phase_d);
      data_oe_q    <= bus_active_d && wr_phase_d;
      data_out_q   <= addr_phase_d ? addr_d : wdata_d;
      otg_addr_q   <= addr_phase_d ? HPI_ADDRESS : (op_is_mem(op_d) ? HPI_DATA : reg_d);
      if ((state_q == ST_RST_HOLD) && tmr_done) otg_rst_n_q <= 1'b1;
      if (capture) rdata_q <= OTG_DATA;
      int_meta_q   <= OTG_INT;
      int_sync_q   <= int_meta_q;
    end
  end

  assign OTG_DATA  = data_oe_q ? data_out_q : 16'bz;
  assign OTG_ADDR  = otg_addr_q;
  assign OTG_CS_N  = cs_n_q;
  assign OTG_RD_N  = rd_n_q;
  assign OTG_WR_N  = wr_n_q;
  assign OTG_RST_N = otg_rst_n_q;
  assign int_sync  = int_sync_q;
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RECOVER) && tmr_done && !addr_phase_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_hpi_bus_master.sv
// Bench for hpi_bus_master: pin-level chip model plus transaction-level reference.
module tb_hpi_bus_master;
  import hpi_pkg::*;

  localparam int S = 1, P = 4, H = 1, R = 2, RC = 8;
  localparam int ACC = S + P + H + R;

  logic        Clk = 1'b0, Reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = '0, req_reg = '0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        OTG_INT = 1'b0;
  wire         req_ready, rsp_valid, OTG_CS_N, OTG_RD_N, OTG_WR_N, OTG_RST_N, int_sync;
  wire  [15:0] rsp_rdata;
  wire  [1:0]  OTG_ADDR;
  wire  [15:0] OTG_DATA;
  logic [15:0] bus_rdata = '0;
  wire         bus_drive = !OTG_CS_N && !OTG_RD_N;

  assign OTG_DATA = bus_drive ? bus_rdata : 16'bz;

  hpi_bus_master #(.SETUP_CYCLES(S), .STROBE_CYCLES(P), .HOLD_CYCLES(H),
                   .RECOVER_CYCLES(R), .RST_CYCLES(RC)) dut (
    .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_reg(req_reg), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .OTG_DATA(OTG_DATA),
    .OTG_ADDR(OTG_ADDR), .OTG_CS_N(OTG_CS_N), .OTG_RD_N(OTG_RD_N), .OTG_WR_N(OTG_WR_N),
    .OTG_RST_N(OTG_RST_N), .OTG_INT(OTG_INT), .int_sync(int_sync)
  );

  always #10 Clk = ~Clk;

  int checks = 0, failures = 0;
  int idle_oe = 0;
  logic [15:0] exp_rdata = 16'd0;

  typedef struct {
    logic [1:0]  addr;
    bit          addr_chg;
    logic [15:0] wdata;
    bit          wchg;
    logic [15:0] rdata;
    int cs_w, wr_w, rd_w, oe_n, gap;
  } phase_t;

  typedef struct {
    logic [1:0]  addr;
    bit          wr;
    logic [15:0] data;
  } exp_ph_t;

  phase_t phq[$];
  phase_t cur;
  bit     in_cs = 1'b0;
  int     gap_cnt = 100;

  // Pin-level chip: responds to strobes it actually sees on the pins.
  logic [15:0] chip_mem [logic [15:0]];
  logic [15:0] chip_regs [4] = '{16'h0000, 16'h1111, 16'h0000, 16'h3333};
  // Transaction-level reference: updated from the request alone.
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] ref_regs [4] = '{16'h0000, 16'h1111, 16'h0000, 16'h3333};

  function automatic logic [15:0] chip_rd(input logic [1:0] a);
    if (a != HPI_DATA) return chip_regs[a];
    if (chip_mem.exists(chip_regs[2])) return chip_mem[chip_regs[2]];
    return chip_regs[2] ^ 16'hA5A5;
  endfunction

  function automatic void chip_wr(input logic [1:0] a, input logic [15:0] d);
    if (a == HPI_DATA) chip_mem[chip_regs[2]] = d;
    else chip_regs[a] = d;
  endfunction

  function automatic logic [15:0] ref_rd(input logic [1:0] a);
    if (a != HPI_DATA) return ref_regs[a];
    if (ref_mem.exists(ref_regs[2])) return ref_mem[ref_regs[2]];
    return ref_regs[2] ^ 16'hA5A5;
  endfunction

  function automatic void ref_wr(input logic [1:0] a, input logic [15:0] d);
    if (a == HPI_DATA) ref_mem[ref_regs[2]] = d;
    else ref_regs[a] = d;
  endfunction

  always @(negedge Clk) begin
    if (Reset) begin
      in_cs = 1'b0;
      gap_cnt = 100;
    end else if (!OTG_CS_N) begin
      if (!in_cs) begin
        in_cs = 1'b1;
        cur = '{addr: OTG_ADDR, addr_chg: 1'b0, wdata: OTG_DATA, wchg: 1'b0, rdata: 16'd0,
                cs_w: 0, wr_w: 0, rd_w: 0, oe_n: 0, gap: gap_cnt};
      end
      cur.cs_w++;
      if (OTG_ADDR !== cur.addr) cur.addr_chg = 1'b1;
      if (OTG_DATA !== cur.wdata) cur.wchg = 1'b1;
      if (dut.data_oe_q) cur.oe_n++;
      if (!OTG_RD_N) begin cur.rd_w++; cur.rdata = OTG_DATA; end
      if (!OTG_WR_N) begin
        cur.wr_w++;
        if (cur.wr_w == 1) chip_wr(OTG_ADDR, OTG_DATA);
      end
    end else begin
      if (in_cs) begin phq.push_back(cur); in_cs = 1'b0; gap_cnt = 0; end
      gap_cnt++;
      if (dut.data_oe_q) idle_oe++;
    end
    bus_rdata = chip_rd(OTG_ADDR);
  end

  task automatic run_txn(input hpi_op_t op, input logic [1:0] r, input logic [15:0] a,
                         input logic [15:0] w, input bit keep, output int waits);
    exp_ph_t ex[$];
    phase_t  ph;
    int      lat, exp_lat;
    logic [15:0] d;
    waits = 0;
    @(negedge Clk);
    while (!req_ready && waits < 200) begin @(negedge Clk); waits++; end
    checks++;
    if (!req_ready) begin
      failures++;
      $display("FAIL ready_timeout got=0 exp=1");
      return;
    end
    req_valid = 1'b1; req_op = op; req_reg = r; req_addr = a; req_wdata = w;
    case (op)
      REG_READ:  begin d = ref_rd(r); exp_rdata = d; ex.push_back('{r, 1'b0, d}); end
      REG_WRITE: begin ref_wr(r, w); ex.push_back('{r, 1'b1, w}); end
      MEM_READ:  begin
        ref_regs[2] = a; d = ref_rd(HPI_DATA); exp_rdata = d;
        ex.push_back('{HPI_ADDRESS, 1'b1, a}); ex.push_back('{HPI_DATA, 1'b0, d});
      end
      default:   begin
        ref_regs[2] = a; ref_wr(HPI_DATA, w);
        ex.push_back('{HPI_ADDRESS, 1'b1, a}); ex.push_back('{HPI_DATA, 1'b1, w});
      end
    endcase
    exp_lat = (ex.size() == 2) ? 2 * ACC : ACC;
    @(posedge Clk);
    lat = 0;
    do begin
      @(negedge Clk);
      lat++;
      if (!keep) req_valid = 1'b0;
      req_op = 2'($urandom); req_reg = 2'($urandom);
      req_addr = 16'($urandom); req_wdata = 16'($urandom);
    end while (!rsp_valid && lat < 100);
    checks++;
    if (lat != exp_lat) begin failures++; $display("FAIL latency op=%0d got=%0d exp=%0d", op, lat, exp_lat); end
    checks++;
    if (rsp_rdata !== exp_rdata) begin failures++; $display("FAIL rsp_rdata op=%0d got=%h exp=%h", op, rsp_rdata, exp_rdata); end
    checks++;
    if (phq.size() != ex.size()) begin
      failures++;
      $display("FAIL phase_count op=%0d got=%0d exp=%0d", op, phq.size(), ex.size());
      phq.delete();
      return;
    end
    foreach (ex[i]) begin
      ph = phq.pop_front();
      checks++;
      if (ph.addr !== ex[i].addr || ph.addr_chg) begin
        failures++; $display("FAIL otg_addr ph=%0d got=%0d exp=%0d chg=%0d", i, ph.addr, ex[i].addr, ph.addr_chg);
      end
      checks++;
      if (ex[i].wr ? (ph.wr_w != P || ph.rd_w != 0) : (ph.rd_w != P || ph.wr_w != 0)) begin
        failures++; $display("FAIL strobe ph=%0d got wr=%0d rd=%0d exp_wr=%0d width=%0d", i, ph.wr_w, ph.rd_w, ex[i].wr, P);
      end
      checks++;
      if (ph.cs_w != S + P + H) begin failures++; $display("FAIL cs_width ph=%0d got=%0d exp=%0d", i, ph.cs_w, S + P + H); end
      checks++;
      if (ex[i].wr ? (ph.wdata !== ex[i].data || ph.wchg) : (ph.rdata !== ex[i].data)) begin
        failures++; $display("FAIL bus_data ph=%0d got=%h/%h exp=%h", i, ph.wdata, ph.rdata, ex[i].data);
      end
      checks++;
      if (ph.oe_n != (ex[i].wr ? ph.cs_w : 0)) begin
        failures++; $display("FAIL data_oe ph=%0d got=%0d exp=%0d", i, ph.oe_n, ex[i].wr ? ph.cs_w : 0);
      end
      checks++;
      if (ph.gap < R) begin failures++; $display("FAIL cs_gap ph=%0d got=%0d exp>=%0d", i, ph.gap, R); end
    end
  endtask

  task automatic test_reset();
    int  n;
    bit  early_ready;
    #25;
    checks++;
    if ({req_ready, rsp_valid, OTG_CS_N, OTG_RD_N, OTG_WR_N, OTG_RST_N, int_sync} !== 7'b0011100) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0011100",
        {req_ready, rsp_valid, OTG_CS_N, OTG_RD_N, OTG_WR_N, OTG_RST_N, int_sync});
    end
    checks++;
    if ({OTG_ADDR, rsp_rdata, dut.data_oe_q} !== 19'd0) begin
      failures++; $display("FAIL reset_data got addr=%0d rdata=%h oe=%0d exp=0", OTG_ADDR, rsp_rdata, dut.data_oe_q);
    end
    @(negedge Clk);
    Reset = 1'b0;
    n = 0; early_ready = 1'b0;
    do begin
      @(posedge Clk); #1; n++;
      if (!OTG_RST_N && req_ready) early_ready = 1'b1;
    end while (!OTG_RST_N && n < RC + 20);
    checks++;
    if (n != RC) begin failures++; $display("FAIL rst_n_hold got=%0d exp=%0d", n, RC); end
    checks++;
    if (!req_ready || early_ready) begin
      failures++; $display("FAIL ready_after_rst got=%0d early=%0d exp=1", req_ready, early_ready);
    end
  endtask

  task automatic test_reg_write();
    int waits;
    run_txn(REG_WRITE, HPI_MAILBOX, 16'h0000, 16'hBEEF, 1'b0, waits);
    @(negedge Clk);
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      failures++; $display("FAIL post_rsp got=%b exp=01", {rsp_valid, req_ready});
    end
    run_txn(REG_READ, HPI_MAILBOX, 16'h0000, 16'h0000, 1'b0, waits);
  endtask

  task automatic test_mem_read();
    int waits;
    chip_mem[16'h051C] = 16'h0050;
    ref_mem[16'h051C]  = 16'h0050;
    run_txn(MEM_READ, HPI_DATA, 16'h051C, 16'h1234, 1'b0, waits);
  endtask

  task automatic test_back_to_back();
    int waits;
    logic [15:0] w;
    w = 16'($urandom);
    run_txn(MEM_WRITE, HPI_DATA, 16'h0005, w, 1'b1, waits);
    run_txn(REG_READ, HPI_DATA, 16'h0000, 16'h0000, 1'b0, waits);
    checks++;
    if (waits != 0) begin failures++; $display("FAIL back_to_back_accept got=%0d exp=0", waits); end
  endtask

  task automatic test_random();
    int waits;
    for (int i = 0; i < 24; i++) begin
      run_txn(hpi_op_t'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              16'($urandom_range(0, 7)), 16'($urandom), 1'b0, waits);
    end
    checks++;
    if (idle_oe != 0) begin failures++; $display("FAIL idle_drive got=%0d exp=0", idle_oe); end
  endtask

  task automatic test_int();
    int waits;
    fork
      run_txn(MEM_READ, HPI_DATA, 16'h051C, 16'h0000, 1'b0, waits);
      begin
        @(posedge Clk); #3 OTG_INT = 1'b1;
        @(posedge Clk); #1;
        checks++;
        if (int_sync !== 1'b0) begin failures++; $display("FAIL int_rise_early got=%b exp=0", int_sync); end
        @(posedge Clk); #1;
        checks++;
        if (int_sync !== 1'b1) begin failures++; $display("FAIL int_rise got=%b exp=1", int_sync); end
        #2 OTG_INT = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        checks++;
        if (int_sync !== 1'b0) begin failures++; $display("FAIL int_fall got=%b exp=0", int_sync); end
      end
    join
  endtask

  task automatic test_mid_reset();
    int n;
    bit saw_rsp;
    @(negedge Clk);
    n = 0;
    while (!req_ready && n < 200) begin @(negedge Clk); n++; end
    req_valid = 1'b1; req_op = REG_WRITE; req_reg = HPI_STATUS; req_wdata = 16'hC0DE;
    @(negedge Clk);
    req_valid = 1'b0;
    n = 0;
    while (OTG_WR_N && n < 50) begin @(negedge Clk); n++; end
    checks++;
    if (OTG_WR_N !== 1'b0) begin failures++; $display("FAIL wr_strobe_timeout got=%b exp=0", OTG_WR_N); end
    ref_wr(HPI_STATUS, 16'hC0DE);
    #3 Reset = 1'b1;
    #1;
    checks++;
    if ({OTG_CS_N, OTG_WR_N, OTG_RD_N, dut.data_oe_q, OTG_RST_N, rsp_valid} !== 6'b111000) begin
      failures++; $display("FAIL mid_reset_pins got=%b exp=111000",
        {OTG_CS_N, OTG_WR_N, OTG_RD_N, dut.data_oe_q, OTG_RST_N, rsp_valid});
    end
    exp_rdata = 16'd0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    n = 0; saw_rsp = 1'b0;
    do begin
      @(posedge Clk); #1; n++;
      if (rsp_valid) saw_rsp = 1'b1;
    end while (!OTG_RST_N && n < RC + 20);
    checks++;
    if (n != RC || saw_rsp) begin
      failures++; $display("FAIL mid_reset_recover got=%0d rsp=%0d exp=%0d rsp=0", n, saw_rsp, RC);
    end
    checks++;
    if (rsp_rdata !== 16'd0) begin failures++; $display("FAIL mid_reset_rdata got=%h exp=0000", rsp_rdata); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_reg_write();
    test_mem_read();
    test_back_to_back();
    test_random();
    test_int();
    test_mid_reset();
    test_reg_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
